uart_rx_debug: RTL and testbench
================================

# uart_rx_debug

Serial receiver in front of the debug unit on the Basys3 board. It samples the asynchronous `receiving` line from the host PC, recovers 8N1 frames with 16x oversampling from an internal baud-tick generator, and delivers each byte with a one-cycle strobe. Downstream, the debug unit's command and instruction-loading FSM consumes `data_o`/`rx_done_o` and assembles bytes into 32-bit instruction words. It runs in the clock-wizard output domain.

## Interface
Parameters:
- `N_BITS`, 8, data bits per frame, sent LSB first.
- `BAUD_DIVISOR`, 163, clock cycles per oversampling tick. 163 gives about 19200 baud x16 at 50 MHz. Must be ≥ 2.
- `NB_DIV`, 8, width of the baud counter. Must satisfy 2^NB_DIV ≥ BAUD_DIVISOR.
- `SB_TICK`, 16, ticks sampled for the stop bit.

Ports:
- `clock_i`  in  1  system clock (clock-wizard output).
- `reset_i`  in  1  reset, **synchronous, active-low**.
- `rx_i`  in  1  asynchronous serial line; idles high.
- `data_o`  out  N_BITS  last correctly received byte. Holds its value until the next good frame.
- `rx_done_o`  out  1  one-cycle pulse; `data_o` is valid in the same cycle.
- `frame_error_o`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx_i` passes through two flops to produce `rx_s`. A third flop holds `rx_prev = rx_s` delayed by one cycle. All three flops reset to 1.
- **Baud generator:**
  - Free-running counter from 0 to BAUD_DIVISOR-1.
  - `tick` is high for one cycle when the count equals BAUD_DIVISOR-1; the counter wraps to 0 in that same cycle.
  - Resets to 0.
- **FSM states:** IDLE, START, DATA, STOP. Internal registers are tick counter `s_cnt` (4 bits), bit counter `n_cnt`, and shift register `sh`.
- **IDLE:**
  - On a falling edge (`rx_prev`=1 and `rx_s`=0), go to START with `s_cnt`=0.
  - The edge is evaluated every cycle, independent of `tick`.
  - A line held low does not retrigger a frame.
- **START (on tick):**
  - If `s_cnt`=7 (mid start bit):
    - `rx_s`=0: go to DATA with `s_cnt`=0 and `n_cnt`=0.
    - `rx_s`=1: treat as a glitch and return to IDLE with no output pulse.
  - Otherwise increment `s_cnt`.
- **DATA (on tick):**
  - If `s_cnt`=15: shift right with `sh <= {rx_s, sh[N_BITS-1:1]}` and set `s_cnt`=0.
    - If `n_cnt`=N_BITS-1, go to STOP.
    - Otherwise increment `n_cnt`.
  - Otherwise increment `s_cnt`.
- **STOP (on tick):**
  - If `s_cnt`=SB_TICK-1:
    - `rx_s`=1: load `data_o <= sh` and pulse `rx_done_o`.
    - `rx_s`=0: pulse `frame_error_o`; `data_o` is unchanged.
    - In both cases return to IDLE.
  - Otherwise increment `s_cnt`.
- `rx_done_o` and `frame_error_o` are registered. They are never high in the same cycle.
- `busy_o` is registered and is 1 from the cycle after IDLE exits up to and including the cycle the done or error pulse asserts.
- **Break (line low for longer than a frame):** produces exactly one `frame_error_o`. The FSM then waits in IDLE for the next high-to-low edge.

## Timing
- **Reset:** while `reset_i`=0 at a clock edge, the following hold on the next cycle:
  - `data_o`=0, `rx_done_o`=0, `frame_error_o`=0, `busy_o`=0.
  - State=IDLE; `s_cnt`, `n_cnt`, `sh` and the baud counter are 0; synchronizer flops are 1.
- Reset asserted mid-frame aborts the frame with no pulse.
- **Input latency:** 2 cycles from an `rx_i` change to `rx_s`. START is entered 1 cycle after `rx_s` falls.
- **Frame latency:** `rx_done_o` asserts 8 + 16·N_BITS + SB_TICK ticks after START entry. The first tick arrives 0 to BAUD_DIVISOR-1 cycles after entry, so the start-detection jitter is at most one tick (1/16 bit).
- **Sample points:** start, data and stop bits are sampled at 8/16 of each bit time, ±1 tick.
- **Back-to-back frames:** the FSM returns to IDLE in the same cycle as the done pulse and can detect the next start edge on the following cycle. There is no dead time beyond the stop bit.
- **Consumer contract:** the consumer must capture `data_o` within one byte time. There is no overrun flag; `data_o` is overwritten only on the next good frame.

## Test plan
All scenarios use BAUD_DIVISOR=4, so one bit is 64 cycles, unless noted.
- **Single byte:** drive 0xA5 as an 8N1 frame → exactly one `rx_done_o` pulse, `data_o`=0xA5, `frame_error_o` never high, `busy_o` low afterwards.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `rx_done_o` pulses carrying 0x00 then 0xFF; pulse spacing is 640 cycles ±4.
- **Glitch:** after receiving 0x3C, drive `rx_i` low for 16 cycles (<8 ticks) then high → no pulses, FSM back in IDLE, `data_o` still 0x3C.
- **Framing error:** send 0x5A with the stop bit low → one `frame_error_o` pulse, no `rx_done_o`, `data_o` keeps its previous value; a following good frame 0x11 is received correctly.
- **Break:** hold `rx_i` low for 30 bit times then high, then send 0x7E → exactly one `frame_error_o`, then `rx_done_o` with 0x7E.
- **Reset mid-frame:** assert `reset_i`=0 during data bit 4 of 0xC3 → all outputs 0 next cycle, no pulse; after release, 0x96 is received correctly.

Source files
------------

// File: rtl/uart_rx_debug_if.sv
// uart_rx_debug_if: serial line in, received byte and status strobes out.
interface uart_rx_debug_if #(parameter int N_BITS = 8);
    logic              rx_i;
    logic [N_BITS-1:0] data_o;
    logic              rx_done_o;
    logic              frame_error_o;
    logic              busy_o;
    modport master (output rx_i, input data_o, rx_done_o, frame_error_o, busy_o);
    modport slave  (input rx_i, output data_o, rx_done_o, frame_error_o, busy_o);
endinterface

// File: rtl/uart_rx_debug.sv
// uart_rx_debug: 8N1 UART receiver with 16x oversampling for the debug unit.
module uart_rx_debug #(
    parameter int N_BITS       = 8,
    parameter int BAUD_DIVISOR = 163,
    parameter int NB_DIV       = 8,
    parameter int SB_TICK      = 16
) (
    input logic            clock_i,
    input logic            reset_i,
    uart_rx_debug_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    localparam int NB_N = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    logic              r_sync1, r_rx_s, r_rx_prev;
    logic [NB_DIV-1:0] r_baud;
    logic [1:0]        r_state;
    logic [3:0]        r_s_cnt;
    logic [NB_N-1:0]   r_n_cnt;
    logic [N_BITS-1:0] r_sh, r_data;
    logic              r_done, r_err, r_busy;
    logic              w_tick, w_fall;

    assign w_tick = r_baud == NB_DIV'(BAUD_DIVISOR - 1);
    assign w_fall = r_rx_prev & ~r_rx_s;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_baud    <= '0;
        end else begin
            r_sync1   <= bus.rx_i;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
            r_baud    <= w_tick ? '0 : r_baud + 1'b1;
        end
    end

    // busy lags the state by a cycle so it still covers the done/error pulse cycle
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= r_state != IDLE;
            case (r_state)
                IDLE: if (w_fall) begin
                    r_state <= START;
                    r_s_cnt <= '0;
                end
                START: if (w_tick) begin
                    if (r_s_cnt == 4'd7) begin
                        r_state <= r_rx_s ? IDLE : DATA;
                        r_s_cnt <= '0;
                        r_n_cnt <= '0;
                    end else r_s_cnt <= r_s_cnt + 1'b1;
                end
                DATA: if (w_tick) begin
                    if (r_s_cnt == 4'd15) begin
                        r_sh    <= {r_rx_s, r_sh[N_BITS-1:1]};
                        r_s_cnt <= '0;
                        if (r_n_cnt == NB_N'(N_BITS - 1)) r_state <= STOP;
                        else r_n_cnt <= r_n_cnt + 1'b1;
                    end else r_s_cnt <= r_s_cnt + 1'b1;
                end
                default: if (w_tick) begin
                    if (r_s_cnt == 4'(SB_TICK - 1)) begin
                        r_done  <= r_rx_s;
                        r_err   <= ~r_rx_s;
                        r_state <= IDLE;
                        if (r_rx_s) r_data <= r_sh;
                    end else r_s_cnt <= r_s_cnt + 1'b1;
                end
            endcase
        end
    end

    assign bus.data_o        = r_data;
    assign bus.rx_done_o     = r_done;
    assign bus.frame_error_o = r_err;
    assign bus.busy_o        = r_busy;
endmodule

// File: tb/tb_uart_rx_debug.sv
// tb_uart_rx_debug: table-driven frames plus glitch/break/reset sequences, checked by a pulse scoreboard.
module tb_uart_rx_debug;
    localparam int BIT = 64;
    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clock_i = ~clock_i;

    uart_rx_debug_if #(.N_BITS(8)) u_if ();
    uart_rx_debug #(.N_BITS(8), .BAUD_DIVISOR(4), .NB_DIV(3), .SB_TICK(16)) u_dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .bus    (u_if)
    );

    typedef struct { logic err; logic [7:0] data; } exp_t;
    typedef struct { logic [7:0] tx; logic stop; int gap; logic exp_err; logic [7:0] exp_data; } vec_t;

    exp_t   q[$];
    exp_t   m_e;
    longint done_cyc[$];
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock_i) begin
        cyc++;
        if (u_if.rx_done_o === 1'b1 || u_if.frame_error_o === 1'b1) begin
            if (u_if.rx_done_o) done_cyc.push_back(cyc);
            check("pulse_exclusive", {31'd0, u_if.rx_done_o & u_if.frame_error_o}, 0);
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: done=%b err=%b data=%h expected no pulse",
                         u_if.rx_done_o, u_if.frame_error_o, u_if.data_o);
            end else begin
                m_e = q.pop_front();
                check("pulse_kind_err", {31'd0, u_if.frame_error_o}, {31'd0, m_e.err});
                check("pulse_data", {24'd0, u_if.data_o}, {24'd0, m_e.data});
            end
        end
    end

    task automatic drive_bit(input logic b);
        u_if.rx_i = b;
        repeat (BIT) @(negedge clock_i);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        repeat (gap) drive_bit(1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && q.size() != 0; k++) @(negedge clock_i);
        check("drain_empty", q.size(), 0);
        q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, {24'd0, u_if.data_o}, 0);
        check({tag, "_done"}, {31'd0, u_if.rx_done_o}, 0);
        check({tag, "_err"}, {31'd0, u_if.frame_error_o}, 0);
        check({tag, "_busy"}, {31'd0, u_if.busy_o}, 0);
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] c3;
        longint     sp;
        vecs[0] = '{8'hA5, 1'b1, 2, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 2, 1'b0, 8'h3C};
        vecs[4] = '{8'h5A, 1'b0, 2, 1'b1, 8'h3C};
        vecs[5] = '{8'h11, 1'b1, 2, 1'b0, 8'h11};
        u_if.rx_i = 1'b1;
        reset_i = 1'b0;
        repeat (4) @(negedge clock_i);
        check_outputs_zero("reset");
        reset_i = 1'b1;
        repeat (2 * BIT) @(negedge clock_i);

        foreach (vecs[i]) begin
            q.push_back('{vecs[i].exp_err, vecs[i].exp_data});
            send(vecs[i].tx, vecs[i].stop, vecs[i].gap);
        end
        drain();
        sp = (done_cyc.size() >= 3) ? done_cyc[2] - done_cyc[1] : 0;
        n_tests++;
        if (sp < 636 || sp > 644) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected 640 +-4", sp);
        end
        check("busy_after_frames", {31'd0, u_if.busy_o}, 0);

        q.push_back('{1'b0, 8'h3C});
        send(8'h3C, 1'b1, 2);
        drain();
        u_if.rx_i = 1'b0;
        repeat (16) @(negedge clock_i);
        u_if.rx_i = 1'b1;
        repeat (12 * BIT) @(negedge clock_i);
        check("glitch_busy", {31'd0, u_if.busy_o}, 0);
        check("glitch_data", {24'd0, u_if.data_o}, 32'h3C);
        check("glitch_state_idle", {30'd0, u_dut.r_state}, 0);

        q.push_back('{1'b1, 8'h3C});
        q.push_back('{1'b0, 8'h7E});
        u_if.rx_i = 1'b0;
        repeat (30 * BIT) @(negedge clock_i);
        u_if.rx_i = 1'b1;
        repeat (2 * BIT) @(negedge clock_i);
        send(8'h7E, 1'b1, 2);
        drain();

        c3 = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(c3[i]);
        u_if.rx_i = c3[4];
        repeat (BIT / 2) @(negedge clock_i);
        check("midframe_busy", {31'd0, u_if.busy_o}, 1);
        reset_i = 1'b0;
        u_if.rx_i = 1'b1;
        @(negedge clock_i);
        check_outputs_zero("midreset");
        reset_i = 1'b1;
        repeat (12 * BIT) @(negedge clock_i);
        check("post_reset_data", {24'd0, u_if.data_o}, 0);
        q.push_back('{1'b0, 8'h96});
        send(8'h96, 1'b1, 2);
        drain();
        check("final_busy", {31'd0, u_if.busy_o}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
